// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable frame format, selectable baud rate and a frame FIFO.
// Optional build macro: UART_RX_MAJORITY_VOTE_EN (2-of-3 sample vote around each mid-bit).
module uart_rx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          serialInput,
    input  logic [1:0]                    baudRate,
    input  logic                          parityEn,
    input  logic                          pType,
    input  logic                          dataReady,
    output logic                          dataValid,
    output logic [DATA_BITS-1:0]          dataOut,
    output logic                          parityError,
    output logic                          frameError,
    output logic                          overrunError,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam int DIV0   = (CLK_FREQ + 2400  * OVERSAMPLE / 2) / (2400  * OVERSAMPLE);
    localparam int DIV1   = (CLK_FREQ + 4800  * OVERSAMPLE / 2) / (4800  * OVERSAMPLE);
    localparam int DIV2   = (CLK_FREQ + 9600  * OVERSAMPLE / 2) / (9600  * OVERSAMPLE);
    localparam int DIV3   = (CLK_FREQ + 19200 * OVERSAMPLE / 2) / (19200 * OVERSAMPLE);
    localparam int TICK_W = (DIV0 > 2) ? $clog2(DIV0) : 1;
    localparam int BT_W   = $clog2(OVERSAMPLE);
    localparam int BC_W   = 4;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = DATA_BITS + 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, rx_prev_q;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BT_W-1:0]      bit_tick_q, bit_tick_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic [1:0]           baud_q, baud_d;
    logic                 par_en_q, par_en_d, p_type_q, p_type_d;
    logic                 push_q, push_d;
    logic                 overrun_q, overrun_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];

    logic                 rx, start_edge, tick, sample_pt, bit_val;
    logic [TICK_W-1:0]    div_m1;
    logic                 pop, full, do_write;
    logic [ENT_W-1:0]     head;

    assign rx         = sync2_q;
    assign start_edge = rx_prev_q & ~rx;

    always_comb begin
        case (baud_q)
            2'b00:   div_m1 = TICK_W'(DIV0 - 1);
            2'b01:   div_m1 = TICK_W'(DIV1 - 1);
            2'b10:   div_m1 = TICK_W'(DIV2 - 1);
            default: div_m1 = TICK_W'(DIV3 - 1);
        endcase
    end

    assign tick = (state_q != IDLE) && (tick_cnt_q == div_m1);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic s0_q, s0_d, s1_q, s1_d;

    // Decision lands one tick after mid-bit, once all three votes are in.
    assign sample_pt = tick && (bit_tick_q == BT_W'(OVERSAMPLE / 2));
    assign bit_val   = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);

    always_comb begin
        s0_d = s0_q;
        s1_d = s1_q;
        if (tick && (bit_tick_q == BT_W'(OVERSAMPLE / 2 - 2))) s0_d = rx;
        if (tick && (bit_tick_q == BT_W'(OVERSAMPLE / 2 - 1))) s1_d = rx;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
        end
    end
`else
    assign sample_pt = tick && (bit_tick_q == BT_W'(OVERSAMPLE / 2 - 1));
    assign bit_val   = rx;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        baud_d     = baud_q;
        par_en_d   = par_en_q;
        p_type_d   = p_type_q;
        push_d     = 1'b0;
        tick_cnt_d = (state_q == IDLE || tick) ? '0 : tick_cnt_q + 1'b1;
        bit_tick_d = bit_tick_q;
        if (state_q == IDLE)
            bit_tick_d = '0;
        else if (tick)
            bit_tick_d = (bit_tick_q == BT_W'(OVERSAMPLE - 1)) ? '0 : bit_tick_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                    baud_d    = baudRate;
                    par_en_d  = parityEn;
                    p_type_d  = pType;
                end
            end
            START: begin
                if (sample_pt) state_d = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (sample_pt) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                // Odd parity (pType=0) wants an odd total ones count, even parity an even one.
                if (sample_pt) begin
                    perr_d  = ~(^shift_q ^ bit_val ^ p_type_q);
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sample_pt) begin
                    if (!bit_val) ferr_d = 1'b1;
                    if (bit_cnt_q == BC_W'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        push_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_tick_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            baud_q     <= 2'b00;
            par_en_q   <= 1'b0;
            p_type_q   <= 1'b0;
            push_q     <= 1'b0;
        end else begin
            sync1_q    <= serialInput;
            sync2_q    <= sync1_q;
            rx_prev_q  <= sync2_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_tick_q <= bit_tick_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            baud_q     <= baud_d;
            par_en_q   <= par_en_d;
            p_type_q   <= p_type_d;
            push_q     <= push_d;
        end
    end

    // A push into a full FIFO still lands if the head is popped on the same edge.
    always_comb begin
        pop       = (count_q != '0) && dataReady;
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        do_write  = push_q && (!full || pop);
        overrun_d = push_q && full && !pop;
        wr_ptr_d  = do_write ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({do_write, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_write) mem_q[wr_ptr_q] <= {shift_q, perr_q, ferr_q};
    end

    assign head         = mem_q[rd_ptr_q];
    assign dataValid    = (count_q != '0);
    assign dataOut      = dataValid ? head[ENT_W-1:2] : '0;
    assign parityError  = dataValid ? head[1] : 1'b0;
    assign frameError   = dataValid ? head[0] : 1'b0;
    assign overrunError = overrun_q;
    assign fifoCount    = count_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed testbench for uart_rx_param, run with a reduced clock frequency so frames are short.
// Divisors at CLK_FREQ=1228800, OVERSAMPLE=16: 32/16/8/4 clocks per tick, bit = 512/256/128/64 clocks.
module tb_uart_rx_param;

    localparam int CLK_FREQ = 1228800;
    localparam int BIT00    = 512;
    localparam int BIT10    = 128;
    localparam int BIT11    = 64;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       serialInput = 1'b1;
    logic [1:0] baudRate = 2'b00;
    logic       parityEn = 1'b0;
    logic       pType = 1'b0;
    logic       dataReady = 1'b0;
    logic       dataValid;
    logic [7:0] dataOut;
    logic       parityError;
    logic       frameError;
    logic       overrunError;
    logic [2:0] fifoCount;

    int total = 0;
    int bad = 0;
    int ovr_pulses = 0;

    uart_rx_param #(
        .CLK_FREQ(CLK_FREQ), .DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4)
    ) dut (
        .clock(clock), .rst(rst), .serialInput(serialInput), .baudRate(baudRate),
        .parityEn(parityEn), .pType(pType), .dataReady(dataReady), .dataValid(dataValid),
        .dataOut(dataOut), .parityError(parityError), .frameError(frameError),
        .overrunError(overrunError), .fifoCount(fifoCount)
    );

    always #10 clock = ~clock;

    always @(negedge clock) if (overrunError === 1'b1) ovr_pulses++;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_frame(input logic [7:0] data, input bit has_par, input logic pbit,
                              input logic stop_val, input int bit_cyc);
        @(posedge clock); #1 serialInput = 1'b0;
        repeat (bit_cyc) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            #1 serialInput = data[i];
            repeat (bit_cyc) @(posedge clock);
        end
        if (has_par) begin
            #1 serialInput = pbit;
            repeat (bit_cyc) @(posedge clock);
        end
        #1 serialInput = stop_val;
        repeat (bit_cyc) @(posedge clock);
        #1 serialInput = 1'b1;
    endtask

    task automatic pop_one();
        @(posedge clock); #1 dataReady = 1'b1;
        @(posedge clock); #1 dataReady = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        rst = 1'b1; serialInput = 1'b1; dataReady = 1'b0;
        repeat (10) @(posedge clock); #1;
        total++; if (dataValid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b want 0", dataValid); end
        total++; if (dataOut !== 8'h00) begin bad++; $display("[TB] FAIL rst_data: got %h want 00", dataOut); end
        total++; if (parityError !== 1'b0) begin bad++; $display("[TB] FAIL rst_perr: got %b want 0", parityError); end
        total++; if (frameError !== 1'b0) begin bad++; $display("[TB] FAIL rst_ferr: got %b want 0", frameError); end
        total++; if (overrunError !== 1'b0) begin bad++; $display("[TB] FAIL rst_ovr: got %b want 0", overrunError); end
        total++; if (fifoCount !== 3'd0) begin bad++; $display("[TB] FAIL rst_count: got %0d want 0", fifoCount); end
        rst = 1'b0;
        base = ovr_pulses;
        repeat (2000) @(posedge clock); #1;
        total++; if (fifoCount !== 3'd0) begin bad++; $display("[TB] FAIL idle_count: got %0d want 0", fifoCount); end
        total++; if (dataValid !== 1'b0) begin bad++; $display("[TB] FAIL idle_valid: got %b want 0", dataValid); end
        total++; if (ovr_pulses != base) begin bad++; $display("[TB] FAIL idle_ovr: got %0d want 0", ovr_pulses - base); end
    endtask

    task automatic test_parity_odd();
        baudRate = 2'b00; parityEn = 1'b1; pType = 1'b0;
        fork
            send_frame(8'h55, 1'b1, 1'b1, 1'b1, BIT00);
            begin
                // stop decision 3 sync/edge clocks after the true mid-stop (tick 168); write one clock later
                @(posedge clock);
                repeat (168 * 32 + 3) @(posedge clock); #1;
                total++; if (dataValid !== 1'b0) begin bad++; $display("[TB] FAIL odd_valid_early: got %b want 0", dataValid); end
                @(posedge clock); #1;
                total++; if (dataValid !== 1'b1) begin bad++; $display("[TB] FAIL odd_valid_time: got %b want 1", dataValid); end
            end
        join
        total++; if (dataOut !== 8'h55) begin bad++; $display("[TB] FAIL odd_data: got %h want 55", dataOut); end
        total++; if (parityError !== 1'b0) begin bad++; $display("[TB] FAIL odd_perr: got %b want 0", parityError); end
        total++; if (frameError !== 1'b0) begin bad++; $display("[TB] FAIL odd_ferr: got %b want 0", frameError); end
        total++; if (fifoCount !== 3'd1) begin bad++; $display("[TB] FAIL odd_count: got %0d want 1", fifoCount); end
        pop_one();
        total++; if (fifoCount !== 3'd0) begin bad++; $display("[TB] FAIL odd_pop: got %0d want 0", fifoCount); end
    endtask

    task automatic test_parity_even();
        baudRate = 2'b11; parityEn = 1'b1; pType = 1'b1;
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1, BIT11);
        total++; if (dataOut !== 8'h0F) begin bad++; $display("[TB] FAIL even_data: got %h want 0f", dataOut); end
        total++; if (parityError !== 1'b0) begin bad++; $display("[TB] FAIL even_perr_ok: got %b want 0", parityError); end
        total++; if (frameError !== 1'b0) begin bad++; $display("[TB] FAIL even_ferr: got %b want 0", frameError); end
        pop_one();
        send_frame(8'h0F, 1'b1, 1'b1, 1'b1, BIT11);
        total++; if (dataOut !== 8'h0F) begin bad++; $display("[TB] FAIL even_bad_data: got %h want 0f", dataOut); end
        total++; if (parityError !== 1'b1) begin bad++; $display("[TB] FAIL even_perr_bad: got %b want 1", parityError); end
        pop_one();
        total++; if (fifoCount !== 3'd0) begin bad++; $display("[TB] FAIL even_pop: got %0d want 0", fifoCount); end
    endtask

    task automatic test_frame_error();
        baudRate = 2'b10; parityEn = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, BIT10);
        total++; if (dataOut !== 8'hA5) begin bad++; $display("[TB] FAIL ferr_data: got %h want a5", dataOut); end
        total++; if (frameError !== 1'b1) begin bad++; $display("[TB] FAIL ferr_flag: got %b want 1", frameError); end
        total++; if (parityError !== 1'b0) begin bad++; $display("[TB] FAIL ferr_perr: got %b want 0", parityError); end
        pop_one();
        baudRate = 2'b11;
        @(posedge clock); #1 serialInput = 1'b0;
        repeat (12 * BIT11) @(posedge clock);
        #1 serialInput = 1'b1;
        repeat (300) @(posedge clock); #1;
        total++; if (fifoCount !== 3'd1) begin bad++; $display("[TB] FAIL break_count: got %0d want 1", fifoCount); end
        total++; if (dataOut !== 8'h00) begin bad++; $display("[TB] FAIL break_data: got %h want 00", dataOut); end
        total++; if (frameError !== 1'b1) begin bad++; $display("[TB] FAIL break_ferr: got %b want 1", frameError); end
        pop_one();
    endtask

    task automatic test_glitch();
        baudRate = 2'b00; parityEn = 1'b0;
        @(posedge clock); #1 serialInput = 1'b0;
        repeat (100) @(posedge clock);
        #1 serialInput = 1'b1;
        repeat (1000) @(posedge clock); #1;
        total++; if (fifoCount !== 3'd0) begin bad++; $display("[TB] FAIL glitch_count: got %0d want 0", fifoCount); end
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, BIT00);
        total++; if (dataOut !== 8'h5A) begin bad++; $display("[TB] FAIL glitch_recover: got %h want 5a", dataOut); end
        pop_one();
    endtask

    task automatic test_back_to_back();
        int base;
        logic [7:0] exp_q [4];
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h06};
        baudRate = 2'b10; parityEn = 1'b0; dataReady = 1'b0;
        base = ovr_pulses;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1, BIT10);
        total++; if (fifoCount !== 3'd4) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 4", fifoCount); end
        total++; if (ovr_pulses - base != 1) begin bad++; $display("[TB] FAIL b2b_ovr: got %0d want 1", ovr_pulses - base); end
        total++; if (dataOut !== 8'h01) begin bad++; $display("[TB] FAIL b2b_head: got %h want 01", dataOut); end
        fork
            send_frame(8'h06, 1'b0, 1'b0, 1'b1, BIT10);
            begin
                // pop exactly on the write edge of frame 6 (stop decision at tick 152)
                @(posedge clock);
                repeat (152 * 8 + 3) @(posedge clock);
                #1 dataReady = 1'b1;
                @(posedge clock); #1 dataReady = 1'b0;
            end
        join
        total++; if (fifoCount !== 3'd4) begin bad++; $display("[TB] FAIL full_pushpop_count: got %0d want 4", fifoCount); end
        total++; if (ovr_pulses - base != 1) begin bad++; $display("[TB] FAIL full_pushpop_ovr: got %0d want 1", ovr_pulses - base); end
        for (int i = 0; i < 4; i++) begin
            total++; if (dataOut !== exp_q[i]) begin bad++; $display("[TB] FAIL drain_%0d: got %h want %h", i, dataOut, exp_q[i]); end
            pop_one();
        end
        total++; if (fifoCount !== 3'd0) begin bad++; $display("[TB] FAIL drain_count: got %0d want 0", fifoCount); end
    endtask

    task automatic test_reset_mid_frame();
        baudRate = 2'b10; parityEn = 1'b0; dataReady = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, BIT10);
        total++; if (fifoCount !== 3'd1) begin bad++; $display("[TB] FAIL mid_pre_count: got %0d want 1", fifoCount); end
        @(posedge clock); #1 serialInput = 1'b0;
        repeat (4 * BIT10) @(posedge clock);
        #1 rst = 1'b1;
        repeat (10) @(posedge clock); #1;
        total++; if (fifoCount !== 3'd0) begin bad++; $display("[TB] FAIL mid_flush: got %0d want 0", fifoCount); end
        serialInput = 1'b1;
        repeat (5) @(posedge clock); #1 rst = 1'b0;
        repeat (50) @(posedge clock);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, BIT10);
        total++; if (fifoCount !== 3'd1) begin bad++; $display("[TB] FAIL mid_count: got %0d want 1", fifoCount); end
        total++; if (dataOut !== 8'h3C) begin bad++; $display("[TB] FAIL mid_data: got %h want 3c", dataOut); end
        total++; if ({parityError, frameError} !== 2'b00) begin bad++; $display("[TB] FAIL mid_flags: got %b want 00", {parityError, frameError}); end
        pop_one();
        total++; if (fifoCount !== 3'd0) begin bad++; $display("[TB] FAIL mid_pop: got %0d want 0", fifoCount); end
    endtask

    initial begin
        test_reset();
        test_parity_odd();
        test_parity_even();
        test_frame_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
